// File: rtl/regfile_writeback_pkg.sv
// Shared types and widths for the register-file write-back path.
// The dispatch width and register geometry are fixed here so every consumer agrees on them.
package regfile_writeback_pkg;

    localparam int DISPATCH_WIDTH = 2;
    localparam int RF_NUM_REGS    = 32;
    localparam int NUM_REGS_WIDTH = $clog2(RF_NUM_REGS);
    localparam int RF_REG_WIDTH   = 32;

    typedef struct packed {
        logic [NUM_REGS_WIDTH-1:0] rd;
        logic [RF_REG_WIDTH-1:0]   data;
    } wb_entry_t;

    // x0 is hard-wired zero: such entries occupy a slot but never write.
    function automatic logic writes_reg(input wb_entry_t e);
        return e.rd != '0;
    endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order circular buffer: DISPATCH_WIDTH-wide compacting enqueue, exposes the oldest
// DISPATCH_WIDTH entries and retires a caller-chosen number of them per cycle.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid [0:DISPATCH_WIDTH-1],
    input  wb_entry_t        push_entry [0:DISPATCH_WIDTH-1],
    input  logic [CNT_W-1:0] pop_cnt,
    output logic             push_ready,
    output wb_entry_t        peek_entry [0:DISPATCH_WIDTH-1],
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem_q [0:DEPTH-1];
    wb_entry_t        mem_d [0:DEPTH-1];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] enq_cnt;

    // Ready depends only on registered occupancy, so producers see no combinational path.
    assign push_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(DISPATCH_WIDTH);
    assign count      = count_q;

    always_comb begin
        mem_d   = mem_q;
        enq_cnt = '0;
        if (push_ready) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (push_valid[i]) begin
                    mem_d[tail_q + PTR_W'(enq_cnt)] = push_entry[i];
                    enq_cnt = enq_cnt + CNT_W'(1);
                end
            end
        end
        tail_d  = tail_q + PTR_W'(enq_cnt);
        head_d  = head_q + PTR_W'(pop_cnt);
        count_d = count_q + enq_cnt - pop_cnt;
    end

    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            peek_entry[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back initiator: buffers lane results in order and drains up to
// DISPATCH_WIDTH per cycle, never issuing two writes to one register nor any write to x0.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter  int NUM_REGS  = RF_NUM_REGS,
    parameter  int REG_WIDTH = RF_REG_WIDTH,
    parameter  int DEPTH     = 8,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid [0:DISPATCH_WIDTH-1],
    input  logic [NUM_REGS_WIDTH-1:0] in_rd    [0:DISPATCH_WIDTH-1],
    input  logic [REG_WIDTH-1:0]      in_data  [0:DISPATCH_WIDTH-1],
    output logic                      in_ready,
    output logic [NUM_REGS_WIDTH-1:0] addr_rd  [0:DISPATCH_WIDTH-1],
    output logic [REG_WIDTH-1:0]      rd_data  [0:DISPATCH_WIDTH-1],
    output logic                      rd_wen   [0:DISPATCH_WIDTH-1],
    output logic [CNT_W-1:0]          count,
    output logic                      empty
);

    wb_entry_t        push_entry [0:DISPATCH_WIDTH-1];
    wb_entry_t        peek_entry [0:DISPATCH_WIDTH-1];
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] deq_cnt;
    logic             blocked;

    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            push_entry[i].rd   = in_rd[i];
            push_entry[i].data = RF_REG_WIDTH'(in_data[i]);
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_entry (push_entry),
        .pop_cnt    (deq_cnt),
        .push_ready (in_ready),
        .peek_entry (peek_entry),
        .count      (fifo_count)
    );

    // Slots fill strictly in age order; the first register collision halts the drain so
    // a younger write can never overtake an older one to the same register.
    always_comb begin
        blocked = 1'b0;
        deq_cnt = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            rd_wen[k]  = 1'b0;
            addr_rd[k] = '0;
            rd_data[k] = '0;
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (!blocked && (CNT_W'(k) < fifo_count)) begin
                if (writes_reg(peek_entry[k])) begin
                    for (int j = 0; j < k; j++) begin
                        if (rd_wen[j] && (addr_rd[j] == peek_entry[k].rd)) begin
                            blocked = 1'b1;
                        end
                    end
                end
                if (!blocked) begin
                    deq_cnt = deq_cnt + CNT_W'(1);
                    if (writes_reg(peek_entry[k])) begin
                        rd_wen[k]  = 1'b1;
                        addr_rd[k] = peek_entry[k].rd;
                        rd_data[k] = REG_WIDTH'(peek_entry[k].data);
                    end
                end
            end
        end
    end

    assign count = fifo_count;
    assign empty = (fifo_count == '0);

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        int'(fifo_count) <= DEPTH);

    for (genvar a = 0; a < DISPATCH_WIDTH; a++) begin : g_chk
        a_no_x0 : assert property (@(posedge clk) disable iff (rst)
            rd_wen[a] |-> (addr_rd[a] != '0));
        a_in_range : assert property (@(posedge clk) disable iff (rst)
            rd_wen[a] |-> (int'(addr_rd[a]) < NUM_REGS));
        for (genvar b = a + 1; b < DISPATCH_WIDTH; b++) begin : g_pair
            a_unique : assert property (@(posedge clk) disable iff (rst)
                !(rd_wen[a] && rd_wen[b] && (addr_rd[a] == addr_rd[b])));
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus a randomized run
// against a queue-based model of the in-order write-back buffer.
module tb_regfile_writeback;

    localparam int DW    = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid [0:DW-1];
    logic [4:0]  in_rd    [0:DW-1];
    logic [31:0] in_data  [0:DW-1];
    logic        in_ready;
    logic [4:0]  addr_rd  [0:DW-1];
    logic [31:0] rd_data  [0:DW-1];
    logic        rd_wen   [0:DW-1];
    logic [3:0]  count;
    logic        empty;

    regfile_writeback #(.NUM_REGS(32), .REG_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .in_ready (in_ready),
        .addr_rd  (addr_rd),
        .rd_data  (rd_data),
        .rd_wen   (rd_wen),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    ent_t mq[$];
    ent_t wlog[$];

    logic        exp_wen  [0:DW-1];
    logic [4:0]  exp_addr [0:DW-1];
    logic [31:0] exp_data [0:DW-1];
    int          exp_deq;
    int          exp_count;
    logic        exp_ready;

    logic        act_wen  [0:DW-1];
    logic [4:0]  act_addr [0:DW-1];
    logic [31:0] act_data [0:DW-1];
    logic        act_ready;
    logic [3:0]  act_count;
    logic        act_empty;

    // Oldest-first walk: a write to a register already written this cycle ends the drain.
    task automatic model_expect();
        bit used [0:31];
        bit halt;
        halt = 1'b0;
        for (int r = 0; r < 32; r++) used[r] = 1'b0;
        exp_deq = 0;
        for (int k = 0; k < DW; k++) begin
            exp_wen[k] = 1'b0; exp_addr[k] = '0; exp_data[k] = '0;
        end
        for (int k = 0; k < DW; k++) begin
            if (!halt && k < mq.size()) begin
                if (mq[k].rd != 0 && used[mq[k].rd]) begin
                    halt = 1'b1;
                end else begin
                    exp_deq++;
                    if (mq[k].rd != 0) begin
                        used[mq[k].rd] = 1'b1;
                        exp_wen[k]  = 1'b1;
                        exp_addr[k] = mq[k].rd;
                        exp_data[k] = mq[k].data;
                    end
                end
            end
        end
        exp_count = mq.size();
        exp_ready = (DEPTH - mq.size()) >= DW;
    endtask

    task automatic model_commit();
        ent_t e;
        if (rst) begin
            mq.delete();
        end else begin
            for (int k = 0; k < exp_deq; k++) void'(mq.pop_front());
            if (exp_ready) begin
                for (int i = 0; i < DW; i++) begin
                    if (in_valid[i]) begin
                        e.rd = in_rd[i]; e.data = in_data[i];
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    // One clock: sample outputs mid-cycle, then let the edge happen and advance the model.
    task automatic step();
        ent_t e;
        @(negedge clk);
        model_expect();
        for (int k = 0; k < DW; k++) begin
            act_wen[k] = rd_wen[k]; act_addr[k] = addr_rd[k]; act_data[k] = rd_data[k];
            if (rd_wen[k]) begin
                e.rd = addr_rd[k]; e.data = rd_data[k];
                wlog.push_back(e);
            end
        end
        act_ready = in_ready; act_count = count; act_empty = empty;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_idle();
        for (int i = 0; i < DW; i++) begin
            in_valid[i] = 1'b0; in_rd[i] = '0; in_data[i] = '0;
        end
    endtask

    task automatic set_lanes(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        in_valid[0] = v0; in_rd[0] = r0; in_data[0] = d0;
        in_valid[1] = v1; in_rd[1] = r1; in_data[1] = d1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_lanes(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        step();
        step();
        rst = 1'b0;
        set_idle();
        step();
        total++;
        if (act_count !== 4'd0 || act_empty !== 1'b1 || act_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_status: count=%0d empty=%0b ready=%0b, want 0/1/1",
                     act_count, act_empty, act_ready);
        end
        total++;
        if (act_wen[0] !== 1'b0 || act_wen[1] !== 1'b0 || act_addr[0] !== 5'd0 ||
            act_addr[1] !== 5'd0 || act_data[0] !== 32'd0 || act_data[1] !== 32'd0) begin
            bad++;
            $display("FAIL reset_ports: wen=%0b%0b addr=%0d/%0d data=%0h/%0h, want all zero",
                     act_wen[0], act_wen[1], act_addr[0], act_addr[1], act_data[0], act_data[1]);
        end
    endtask

    task automatic test_dual_write();
        set_lanes(1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB);
        step();
        set_idle();
        step();
        total++;
        if (act_wen[0] !== 1'b1 || act_wen[1] !== 1'b1 || act_addr[0] !== 5'd5 ||
            act_addr[1] !== 5'd6 || act_data[0] !== 32'hA || act_data[1] !== 32'hB) begin
            bad++;
            $display("FAIL dual_write: wen=%0b%0b addr=%0d/%0d data=%0h/%0h, want 11 5/6 a/b",
                     act_wen[0], act_wen[1], act_addr[0], act_addr[1], act_data[0], act_data[1]);
        end
        step();
        total++;
        if (act_count !== 4'd0 || act_wen[0] !== 1'b0 || act_wen[1] !== 1'b0) begin
            bad++;
            $display("FAIL dual_drained: count=%0d wen=%0b%0b, want 0 00",
                     act_count, act_wen[0], act_wen[1]);
        end
    endtask

    task automatic test_same_rd();
        set_lanes(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        step();
        set_idle();
        step();
        total++;
        if (act_wen[0] !== 1'b1 || act_wen[1] !== 1'b0 || act_addr[0] !== 5'd7 ||
            act_data[0] !== 32'd1 || act_count !== 4'd2) begin
            bad++;
            $display("FAIL same_rd_first: wen=%0b%0b addr0=%0d data0=%0h count=%0d, want 10 7 1 2",
                     act_wen[0], act_wen[1], act_addr[0], act_data[0], act_count);
        end
        step();
        total++;
        if (act_wen[0] !== 1'b1 || act_wen[1] !== 1'b0 || act_addr[0] !== 5'd7 ||
            act_data[0] !== 32'd2 || act_count !== 4'd1) begin
            bad++;
            $display("FAIL same_rd_second: wen=%0b%0b addr0=%0d data0=%0h count=%0d, want 10 7 2 1",
                     act_wen[0], act_wen[1], act_addr[0], act_data[0], act_count);
        end
        step();
    endtask

    task automatic test_x0();
        set_lanes(1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'd4);
        step();
        set_idle();
        step();
        total++;
        if (act_wen[0] !== 1'b0 || act_wen[1] !== 1'b1 || act_addr[1] !== 5'd3 ||
            act_data[1] !== 32'd4) begin
            bad++;
            $display("FAIL x0_skip: wen=%0b%0b addr1=%0d data1=%0h, want 01 3 4",
                     act_wen[0], act_wen[1], act_addr[1], act_data[1]);
        end
        step();
        total++;
        if (act_count !== 4'd0 || act_empty !== 1'b1) begin
            bad++;
            $display("FAIL x0_consumed: count=%0d empty=%0b, want 0 1", act_count, act_empty);
        end
    endtask

    task automatic test_fill_wrap();
        int n;
        int saw_full;
        bit done;
        n = 0; saw_full = 0; done = 1'b0;
        wlog.delete();
        for (int c = 0; c < 120 && !done; c++) begin
            if (n < 30) set_lanes(1'b1, 5'd9, 32'h100 + n, 1'b1, 5'd9, 32'h100 + n + 1);
            else set_idle();
            step();
            total++;
            if (act_wen[0] !== exp_wen[0] || act_wen[1] !== exp_wen[1] ||
                act_addr[0] !== exp_addr[0] || act_data[0] !== exp_data[0] ||
                act_count !== 4'(exp_count) || act_ready !== exp_ready) begin
                bad++;
                $display("FAIL fill_cycle%0d: wen=%0b%0b data0=%0h count=%0d ready=%0b, want %0b%0b %0h %0d %0b",
                         c, act_wen[0], act_wen[1], act_data[0], act_count, act_ready,
                         exp_wen[0], exp_wen[1], exp_data[0], exp_count, exp_ready);
            end
            if (act_count > 4'd6) begin
                saw_full++;
                total++;
                if (act_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_ready: count=%0d ready=%0b, want ready 0", act_count, act_ready);
                end
            end
            if (n < 30 && act_ready) n += 2;
            if (n >= 30 && mq.size() == 0 && act_count <= 4'd1) done = 1'b1;
        end
        total++;
        if (!done || saw_full == 0) begin
            bad++;
            $display("FAIL fill_progress: done=%0b full_cycles=%0d, want 1 and >0", done, saw_full);
        end
        total++;
        if (wlog.size() != 30) begin
            bad++;
            $display("FAIL fill_write_count: writes=%0d, want 30", wlog.size());
        end
        for (int i = 0; i < 30 && i < wlog.size(); i++) begin
            total++;
            if (wlog[i].rd !== 5'd9 || wlog[i].data !== 32'h100 + i) begin
                bad++;
                $display("FAIL fill_order%0d: r%0d=%0h, want r9=%0h", i, wlog[i].rd, wlog[i].data, 32'h100 + i);
            end
        end
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 4; c++) begin
            set_lanes(1'b1, 5'd12, 32'h200 + 2 * c, 1'b1, 5'd12, 32'h201 + 2 * c);
            step();
        end
        set_idle();
        rst = 1'b1;
        step();
        total++;
        if (act_count !== 4'd5) begin
            bad++;
            $display("FAIL rst_mid_pre: count=%0d, want 5", act_count);
        end
        rst = 1'b0;
        wlog.delete();
        step();
        total++;
        if (act_count !== 4'd0 || act_wen[0] !== 1'b0 || act_wen[1] !== 1'b0 || act_empty !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_post: count=%0d wen=%0b%0b empty=%0b, want 0 00 1",
                     act_count, act_wen[0], act_wen[1], act_empty);
        end
        for (int c = 0; c < 5; c++) step();
        total++;
        if (wlog.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_leak: writes after reset=%0d, want 0", wlog.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < DW; i++) begin
                in_valid[i] = ($urandom_range(0, 9) < 7);
                in_rd[i]    = 5'($urandom_range(0, 5));
                in_data[i]  = $urandom;
            end
            step();
            for (int k = 0; k < DW; k++) begin
                total++;
                if (act_wen[k] !== exp_wen[k] || act_addr[k] !== exp_addr[k] ||
                    act_data[k] !== exp_data[k]) begin
                    bad++;
                    $display("FAIL rand_slot%0d_cyc%0d: wen=%0b addr=%0d data=%0h, want %0b %0d %0h",
                             k, c, act_wen[k], act_addr[k], act_data[k], exp_wen[k], exp_addr[k], exp_data[k]);
                end
            end
            total++;
            if (act_count !== 4'(exp_count) || act_ready !== exp_ready || act_empty !== (exp_count == 0)) begin
                bad++;
                $display("FAIL rand_status_cyc%0d: count=%0d ready=%0b empty=%0b, want %0d %0b %0b",
                         c, act_count, act_ready, act_empty, exp_count, exp_ready, exp_count == 0);
            end
        end
        set_idle();
        for (int c = 0; c < 20; c++) step();
        total++;
        if (act_count !== 4'd0) begin
            bad++;
            $display("FAIL rand_drain: count=%0d, want 0", act_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_dual_write();
        test_same_rd();
        test_x0();
        test_fill_wrap();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
